// File: rtl/ram16k_arbiter_pkg.sv
// Shared types and default sizes for the RAM16k two-port arbiter.
// Owner and last-served encodings are used by both the top and the picker.
package ram16k_arbiter_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 14;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  function automatic side_t side_of(input owner_t own);
    return (own == OWN_A) ? SIDE_A : SIDE_B;
  endfunction

endpackage

// File: rtl/ram16k_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick with bounded burst.
// A lone requester always wins; contention keeps the owner until its burst is full.
module ram16k_arbiter_rr_pick2
  import ram16k_arbiter_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_t owner,
  input  logic   cnt_full,
  input  side_t  last_served,
  output logic   gnt_a,
  output logic   gnt_b
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && !req_b) begin
      gnt_a = 1'b1;
    end else if (req_b && !req_a) begin
      gnt_b = 1'b1;
    end else if (req_a && req_b) begin
      if (owner == OWN_A && !cnt_full) begin
        gnt_a = 1'b1;
      end else if (owner == OWN_B && !cnt_full) begin
        gnt_b = 1'b1;
      end else if (last_served == SIDE_B) begin
        gnt_a = 1'b1;
      end else begin
        gnt_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram16k_arbiter.sv
// Shares one RAM16k between requesters A (CPU) and B (DMA/refresh).
// Holds arbitration state, drives the RAM directly and registers read data back.
module ram16k_arbiter
  import ram16k_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_req,
  input  logic              a_load,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_in,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_out,

  input  logic              b_req,
  input  logic              b_load,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_in,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_out,

  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  owner_t           owner_q, owner_d;
  side_t            last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_full;
  logic             pick_a, pick_b;
  owner_t           granted;

  assign cnt_full = (cnt_q == CNT_MAX);

  ram16k_arbiter_rr_pick2 u_pick (
    .req_a       (a_req),
    .req_b       (b_req),
    .owner       (owner_q),
    .cnt_full    (cnt_full),
    .last_served (last_q),
    .gnt_a       (pick_a),
    .gnt_b       (pick_b)
  );

  // Grants are masked during reset so no access (and no write) reaches the RAM.
  assign a_gnt = pick_a & ~reset;
  assign b_gnt = pick_b & ~reset;

  always_comb begin
    granted = OWN_NONE;
    if (a_gnt) begin
      granted = OWN_A;
    end else if (b_gnt) begin
      granted = OWN_B;
    end
  end

  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    if (a_gnt) begin
      ram_address = a_address;
      ram_in      = a_in;
      ram_load    = a_load;
    end else if (b_gnt) begin
      ram_address = b_address;
      ram_in      = b_in;
      ram_load    = b_load;
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (granted == OWN_NONE) begin
      owner_d = OWN_NONE;
      cnt_d   = '0;
    end else if (granted == owner_q) begin
      if (!cnt_full) cnt_d = cnt_q + CNT_ONE;
    end else begin
      owner_d = granted;
      cnt_d   = CNT_ONE;
      last_d  = side_of(granted);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      last_q  <= SIDE_B;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Read data is captured at the end of the grant cycle and held until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      a_out    <= '0;
      b_rvalid <= 1'b0;
      b_out    <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_load;
      b_rvalid <= b_gnt & ~b_load;
      if (a_gnt && !a_load) a_out <= ram_out;
      if (b_gnt && !b_load) b_out <= ram_out;
    end
  end

endmodule
